// File: rtl/commutator_mdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : commutator_mdc_pkg
//  Purpose  : Shared helpers for the MDC commutator: lane slice macro,
//             ceil-log2 and power-of-two functions, depth limit.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================

// Lane i of a packed bus made of nb-bit lanes.
`ifndef COMMUTATOR_MDC_LANE
`define COMMUTATOR_MDC_LANE(bus, nb, i) bus[(nb)*((i)+1)-1 -: (nb)]
`endif

package commutator_mdc_pkg;

    localparam int c_MAX_DEPTH = 1024;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/commutator_mdc_delay_line_en.sv
`default_nettype none
// ============================================================================
//  Module   : delay_line_en
//  Purpose  : Enabled shift register, DEPTH stages of NB bits, async clear.
//  Ports    : clk     - clock, rising edge
//             reset_n - asynchronous active-low clear of every stage
//             en      - shift enable
//             d       - data in
//             q       - data out, d delayed DEPTH enabled cycles
//  Revision : 1.0  initial release
// ============================================================================
module delay_line_en #(
    parameter int NB    = 16,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic [NB-1:0] d,
    output logic [NB-1:0] q
);

    logic [NB-1:0] r_taps [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_taps[i] <= '0;
            end
        end else if (en) begin
            r_taps[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                r_taps[i] <= r_taps[i-1];
            end
        end
    end

    assign q = r_taps[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/commutator_mdc.sv
`default_nettype none
// ============================================================================
//  Module   : commutator_mdc
//  Purpose  : Multi-path delay commutator between radix-2 FFT stages.
//             Per lane pair: delay even lane DEPTH samples, conditionally
//             swap the pair every DEPTH samples, delay odd lane DEPTH samples.
//  Ports    : clk         - clock, rising edge
//             reset_n     - asynchronous active-low reset
//             start       - frame restart; clears counters, latches bypass
//             bypass      - sampled on start; 1 = never swap
//             in_valid    - sample strobe; all state advances only on it
//             input_data  - 2*PAIRS lanes of NB bits, lane i at [NB*(i+1)-1:NB*i]
//             output_data - same lane packing as input_data
//             out_valid   - output_data holds a frame-aligned sample
//  Revision : 1.0  initial release
// ============================================================================
module commutator_mdc
    import commutator_mdc_pkg::*;
#(
    parameter int NB    = 16,
    parameter int DEPTH = 1,
    parameter int PAIRS = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  bypass,
    input  logic                  in_valid,
    input  logic [NB*2*PAIRS-1:0] input_data,
    output logic [NB*2*PAIRS-1:0] output_data,
    output logic                  out_valid
);

    localparam int c_CNT_W  = clog2(DEPTH) + 1;
    localparam int c_FULL   = 2 * DEPTH;
    localparam int c_FILL_W = clog2(c_FULL) + 1;

    if (!is_pow2(DEPTH) || (DEPTH > c_MAX_DEPTH)) begin : g_bad_depth
        $error("commutator_mdc: DEPTH must be a power of 2 in 1..1024");
    end

    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_FILL_W-1:0]   r_fill;
    logic                  r_bypass_q;
    logic                  w_sel;
    logic                  w_full;
    logic [NB*2*PAIRS-1:0] w_out;

    // Sample counter wraps naturally at 2*DEPTH (its width is log2(2*DEPTH)).
    // A start cycle is sample 0 of the new frame, so the accepted sample
    // leaves the counters at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_fill     <= '0;
            r_bypass_q <= 1'b0;
        end else begin
            if (start) begin
                r_bypass_q <= bypass;
                r_cnt      <= in_valid ? c_CNT_W'(1) : '0;
                r_fill     <= in_valid ? c_FILL_W'(1) : '0;
            end else if (in_valid) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
                if (!w_full) begin
                    r_fill <= r_fill + c_FILL_W'(1);
                end
            end
        end
    end

    assign w_full = (r_fill == c_FILL_W'(c_FULL));

    // The start sample always uses the straight path, regardless of the
    // counter value left over from the previous frame.
    assign w_sel = ~start & r_cnt[c_CNT_W-1] & ~r_bypass_q;

    for (genvar p = 0; p < PAIRS; p++) begin : g_pair
        logic [NB-1:0] w_a;
        logic [NB-1:0] w_b;
        logic [NB-1:0] w_da;
        logic [NB-1:0] w_sw_a;
        logic [NB-1:0] w_sw_b;
        logic [NB-1:0] w_db;

        assign w_a = `COMMUTATOR_MDC_LANE(input_data, NB, 2*p);
        assign w_b = `COMMUTATOR_MDC_LANE(input_data, NB, 2*p+1);

        delay_line_en #(
            .NB    (NB),
            .DEPTH (DEPTH)
        ) u_dly_a (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (in_valid),
            .d       (w_a),
            .q       (w_da)
        );

        assign w_sw_a = w_sel ? w_b  : w_da;
        assign w_sw_b = w_sel ? w_da : w_b;

        delay_line_en #(
            .NB    (NB),
            .DEPTH (DEPTH)
        ) u_dly_b (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (in_valid),
            .d       (w_sw_b),
            .q       (w_db)
        );

        assign `COMMUTATOR_MDC_LANE(w_out, NB, 2*p)   = w_sw_a;
        assign `COMMUTATOR_MDC_LANE(w_out, NB, 2*p+1) = w_db;
    end

    // Even lanes pass the live input combinationally, so force the outputs
    // quiet while reset is held.
    assign output_data = reset_n ? w_out : '0;
    assign out_valid   = reset_n & in_valid & ~start & w_full;

endmodule

`default_nettype wire

// File: tb/tb_commutator_mdc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_commutator_mdc
//  Purpose  : Directed self-checking bench for commutator_mdc. Three
//             instances: DEPTH=1/PAIRS=1, DEPTH=4/PAIRS=2, DEPTH=2/PAIRS=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_commutator_mdc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        sA, bA, vA, ovA;
    logic [31:0] iA, oA;
    logic        sB, bB, vB, ovB;
    logic [63:0] iB, oB;
    logic        sC, bC, vC, ovC;
    logic [31:0] iC, oC;

    int checks = 0;
    int errors = 0;
    int ha [0:511];
    int hb [0:511];
    int g;

    commutator_mdc #(.NB(16), .DEPTH(1), .PAIRS(1)) u_a (
        .clk(clk), .reset_n(reset_n), .start(sA), .bypass(bA), .in_valid(vA),
        .input_data(iA), .output_data(oA), .out_valid(ovA));

    commutator_mdc #(.NB(16), .DEPTH(4), .PAIRS(2)) u_b (
        .clk(clk), .reset_n(reset_n), .start(sB), .bypass(bB), .in_valid(vB),
        .input_data(iB), .output_data(oB), .out_valid(ovB));

    commutator_mdc #(.NB(16), .DEPTH(2), .PAIRS(1)) u_c (
        .clk(clk), .reset_n(reset_n), .start(sC), .bypass(bC), .in_valid(vC),
        .input_data(iC), .output_data(oC), .out_valid(ovC));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Steady-state expectation for a continuous frame (no bypass):
    // first half of each 2*D window passes the delayed even lane, second
    // half passes the live odd lane.
    function automatic int exp_a(input int d, input int k, input int ph);
        if (ph < d) return ha[k-d];
        return hb[k];
    endfunction

    function automatic int exp_b(input int d, input int k, input int ph);
        if (ph < d) return ha[k-2*d];
        return hb[k-d];
    endfunction

    task automatic drive_c(input bit st, input int gi);
        @(negedge clk);
        sC = st;
        vC = 1'b1;
        iC = {16'(500 + gi), 16'(gi + 1)};
        ha[gi] = gi + 1;
        hb[gi] = 500 + gi;
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        {sA, bA, vA, iA} = '0;
        {sB, bB, vB, iB} = '0;
        {sC, bC, vC, iC} = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_oA", oA, 0);
        chk("reset_ovA", 32'(ovA), 0);
        chk("reset_oB_lo", oB[31:0], 0);
        chk("reset_ovC", 32'(ovC), 0);
        reset_n = 1'b1;

        // ---- DEPTH=1 PAIRS=1 basic shuffle ----
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            sA = (k == 0);
            vA = 1'b1;
            iA = {16'(100 + k), 16'(k)};
            ha[k] = k;
            hb[k] = 100 + k;
            #1;
            if (k >= 2) begin
                chk("d1_ov", 32'(ovA), 1);
                chk("d1_a", oA[15:0], exp_a(1, k, k % 2));
                chk("d1_b", oA[31:16], exp_b(1, k, k % 2));
            end else begin
                chk("d1_ov_fill", 32'(ovA), 0);
            end
            if (k == 2) begin
                chk("d1_k2_a", oA[15:0], 1);
                chk("d1_k2_b", oA[31:16], 0);
            end
            if (k == 3) begin
                chk("d1_k3_a", oA[15:0], 103);
                chk("d1_k3_b", oA[31:16], 102);
            end
        end
        @(negedge clk);
        vA = 1'b0;
        sA = 1'b0;

        // ---- DEPTH=4 PAIRS=2 ----
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            sB = (k == 0);
            vB = 1'b1;
            iB = {16'(1100 + k), 16'(1000 + k), 16'(100 + k), 16'(k)};
            ha[k] = k;
            hb[k] = 100 + k;
            #1;
            if (k >= 8) begin
                chk("d4_ov", 32'(ovB), 1);
                chk("d4_p0a", oB[15:0],  exp_a(4, k, k % 8));
                chk("d4_p0b", oB[31:16], exp_b(4, k, k % 8));
                chk("d4_p1a", oB[47:32], exp_a(4, k, k % 8) + 1000);
                chk("d4_p1b", oB[63:48], exp_b(4, k, k % 8) + 1000);
            end else begin
                chk("d4_ov_fill", 32'(ovB), 0);
            end
        end
        @(negedge clk);
        vB = 1'b0;
        sB = 1'b0;

        // ---- DEPTH=2 with stalls ----
        g = 0;
        for (int j = 0; j < 14; j++) begin
            if (j == 3 || j == 9) begin
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    vC = 1'b0;
                    sC = 1'b0;
                    iC = '1;
                    #1;
                    chk("stall_ov", 32'(ovC), 0);
                end
                chk("stall_cnt", 32'(u_c.r_cnt), j % 4);
            end
            drive_c(j == 0, g);
            if (j >= 4) begin
                chk("stall_ov_run", 32'(ovC), 1);
                chk("stall_a", oC[15:0],  exp_a(2, g, j % 4));
                chk("stall_b", oC[31:16], exp_b(2, g, j % 4));
            end else begin
                chk("stall_ov_fill", 32'(ovC), 0);
            end
            g++;
        end

        // ---- bypass, with a later bypass change that must be ignored ----
        for (int j = 0; j < 12; j++) begin
            bC = (j < 6);
            drive_c(j == 0, g);
            if (j >= 4) begin
                chk("byp_ov", 32'(ovC), 1);
                chk("byp_a", oC[15:0],  ha[g-2]);
                chk("byp_b", oC[31:16], hb[g-2]);
            end else begin
                chk("byp_ov_fill", 32'(ovC), 0);
            end
            g++;
        end

        // ---- restart mid-frame at sample 5 ----
        bC = 1'b0;
        for (int j = 0; j < 6; j++) begin
            drive_c(j == 0 || j == 5, g);
            if (j == 4) begin
                chk("rst_pre_ov", 32'(ovC), 1);
                chk("rst_pre_a", oC[15:0], exp_a(2, g, 0));
            end
            if (j == 5) begin
                chk("restart_ov", 32'(ovC), 0);
                chk("restart_a_sel0", oC[15:0], ha[g-2]);
            end
            g++;
        end
        @(negedge clk);
        vC = 1'b0;
        sC = 1'b0;
        #1;
        chk("restart_cnt", 32'(u_c.r_cnt), 1);
        for (int f = 1; f < 8; f++) begin
            drive_c(1'b0, g);
            chk("restart_ov_f", 32'(ovC), (f >= 4) ? 1 : 0);
            if (f >= 4) begin
                chk("restart_a", oC[15:0],  exp_a(2, g, f % 4));
                chk("restart_b", oC[31:16], exp_b(2, g, f % 4));
            end
            g++;
        end

        // ---- async reset mid-stream ----
        @(negedge clk);
        sC = 1'b0;
        vC = 1'b1;
        iC = {16'hABCD, 16'h1234};
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_data", oC, 0);
        chk("areset_ov", 32'(ovC), 0);
        chk("areset_cnt", 32'(u_c.r_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int f = 0; f < 6; f++) begin
            drive_c(f == 0, g);
            chk("post_rst_ov", 32'(ovC), (f >= 4) ? 1 : 0);
            if (f >= 4) begin
                chk("post_rst_a", oC[15:0],  exp_a(2, g, f % 4));
                chk("post_rst_b", oC[31:16], exp_b(2, g, f % 4));
            end
            g++;
        end
        @(negedge clk);
        vC = 1'b0;
        sC = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/commutator_mdc.md
Name: commutator_mdc

Overview:
- Parametrised MDC (multi-path delay commutator) between radix-2 butterfly stages of the pipelined FFT.
- Each lane pair runs a delay / swap / delay structure: the even lane is delayed DEPTH samples, the pair is conditionally swapped every DEPTH samples, and the odd lane is then delayed DEPTH samples.
- Generalises the fixed depth-1, 4-lane commutator in three ways: any power-of-2 depth, any pair count, and an in_valid stall handshake plus a latched bypass mode.

Parameters:
- NB, 16, data width per lane (bits).
- DEPTH, 1, delay-line length in samples; power of 2, 1..1024.
- PAIRS, 2, number of lane pairs; lane count = 2*PAIRS.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  synchronous frame restart: clears the sample counter and fill counter, latches bypass.
- bypass  in  1  mode; sampled only when start=1; 1 means never swap.
- in_valid  in  1  sample strobe; all state advances only when in_valid=1.
- input_data  in  NB*2*PAIRS  lane i at bits [NB*(i+1)-1:NB*i].
- output_data  out  NB*2*PAIRS  same lane packing as input_data.
- out_valid  out  1  output_data holds a frame-aligned sample.

Behaviour:
- Reset (async, reset_n=0):
  - sample counter cnt, fill counter, bypass_q and all delay registers cleared to 0.
  - out_valid=0 and output_data=0 while reset_n=0.
- cnt is log2(DEPTH)+1 bits; sel = cnt MSB, forced to 0 when bypass_q=1.
- Per pair p, with a = lane 2p and b = lane 2p+1:
  - da = a delayed DEPTH accepted samples.
  - If sel=0: sw_a=da, sw_b=b. If sel=1: sw_a=b, sw_b=da.
  - out lane 2p = sw_a, combinational from registers and the current input.
  - out lane 2p+1 = sw_b delayed DEPTH accepted samples.
- Delay lines are shift registers (or RAM plus pointer) enabled by in_valid only. With in_valid=0 nothing shifts, cnt holds, and out_valid=0.
- cnt increments modulo 2*DEPTH on each accepted sample (wraps 2*DEPTH-1 to 0).
- start=1:
  - The sample accepted in the same cycle, if in_valid=1, is sample 0 of the new frame and uses sel=0.
  - After that edge, cnt=1 if in_valid was 1, else cnt=0.
  - The fill counter restarts the same way.
  - Delay contents are not cleared.
  - bypass_q <= bypass.
- Fill counter saturates at 2*DEPTH. out_valid = in_valid and (fill counter == 2*DEPTH), using the pre-increment value.
- Latency: 2*DEPTH accepted samples from frame start to the first out_valid. DEPTH=1, PAIRS=2, bypass=0 is cycle-equivalent to the existing commutator whenever in_valid is held at 1.
- Simultaneous start and in_valid: start has priority for the counter clear, and the sample is still accepted as described above.
- reset_n deasserted mid-frame: all state is lost and the next frame needs a start pulse. Without a start, cnt begins at 0 after reset anyway.
- Arithmetic: no data arithmetic; widths are exact and there is no sign handling.

Decomposition:
- Shared fft package/header holds:
  - the lane slice macro;
  - a clog2 function;
  - the DEPTH power-of-2 check, which fails elaboration on violation.
- One sub-module, delay_line_en (params NB, DEPTH; ports clk, reset_n, en, d, q):
  - enabled shift register with async clear;
  - instanced twice per pair.

Test Plan:
- Reset and bypass: reset_n=0 mid-stream -> out_valid=0 and output_data=0 immediately; after release plus start, the first out_valid appears after 2*DEPTH accepted samples.
- Basic shuffle: DEPTH=1, PAIRS=1, start at k=0, in_valid held at 1, a=k, b=100+k.
  - At k=2 the output is (out_a,out_b)=(1,0).
  - At k=3 the output is (103,102).
  - out_valid rises at k=2.
- Depth 4: DEPTH=4, PAIRS=2, same ramp per pair, offset 1000 on pair 1.
  - sel toggles every 4 samples.
  - From k=8 onward each 8-sample window outputs pairs (a_j, a_{j+4}) then (b_j, b_{j+4}).
  - Pair 1 shows identical results +1000.
- Stall: DEPTH=2; insert in_valid=0 for 3 cycles at random points.
  - Output sequence under accepted samples is identical to the no-stall run.
  - out_valid=0 during stalls.
  - cnt is unchanged across the stall.
- Bypass: start with bypass=1, DEPTH=2 -> out_a = a delayed 2 and out_b = b delayed 2 for all samples. Changing bypass without start has no effect.
- Restart: start with in_valid=1 at k=5 mid-frame -> that sample uses sel=0, cnt=1 after, and out_valid drops until 2*DEPTH new samples are accepted.
